// File: rtl/iob_sync_asym_fifo_pkg.sv
// rtl/iob_sync_asym_fifo_pkg.sv - width-ratio helpers shared by the asymmetric FIFO and its RAM
package iob_sync_asym_fifo_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int min_w(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Number of MIN_W-bit storage units that make up one w-bit word
  function automatic int units(input int w, input int mw);
    return w / mw;
  endfunction

endpackage

// File: rtl/iob_t2p_asym_ram.sv
// rtl/iob_t2p_asym_ram.sv - two-port RAM stored in MIN_W units, wide/narrow ports, registered read
module iob_t2p_asym_ram
  import iob_sync_asym_fifo_pkg::*;
#(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 4
) (
  input  logic                wclk,
  input  logic                w_en,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [W_DATA_W-1:0] w_data,
  input  logic                rclk,
  input  logic                arst_n,
  input  logic                rst,
  input  logic                r_en,
  input  logic [ADDR_W-1:0]   r_addr,
  output logic [R_DATA_W-1:0] r_data
);

  localparam int MIN_W = min_w(W_DATA_W, R_DATA_W);
  localparam int WU    = units(W_DATA_W, MIN_W);
  localparam int RU    = units(R_DATA_W, MIN_W);

  logic [MIN_W-1:0]    mem_q [2**ADDR_W];
  logic [R_DATA_W-1:0] rd_word;
  logic [R_DATA_W-1:0] r_data_d, r_data_q;

  // Little-endian: unit k of the word lives at address base+k
  always_ff @(posedge wclk) begin
    if (w_en) begin
      for (int k = 0; k < WU; k++) begin
        mem_q[w_addr + ADDR_W'(k)] <= w_data[k*MIN_W +: MIN_W];
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < RU; k++) begin
      rd_word[k*MIN_W +: MIN_W] = mem_q[r_addr + ADDR_W'(k)];
    end
  end

  always_comb begin
    r_data_d = r_data_q;
    if (rst) begin
      r_data_d = '0;
    end else if (r_en) begin
      r_data_d = rd_word;
    end
  end

  always_ff @(posedge rclk or negedge arst_n) begin
    if (!arst_n) begin
      r_data_q <= '0;
    end else begin
      r_data_q <= r_data_d;
    end
  end

  assign r_data = r_data_q;

endmodule

// File: rtl/iob_sync_asym_fifo.sv
// rtl/iob_sync_asym_fifo.sv - single-clock FIFO with power-of-two asymmetric write/read widths
module iob_sync_asym_fifo
  import iob_sync_asym_fifo_pkg::*;
#(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                rst,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] w_data,
  output logic                w_full,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] r_data,
  output logic                r_empty,
  output logic [ADDR_W:0]     level
);

  localparam int MIN_W = min_w(W_DATA_W, R_DATA_W);
  localparam int WU    = units(W_DATA_W, MIN_W);
  localparam int RU    = units(R_DATA_W, MIN_W);
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [ADDR_W:0] WU_L     = (ADDR_W+1)'(WU);
  localparam logic [ADDR_W:0] RU_L     = (ADDR_W+1)'(RU);
  localparam logic [ADDR_W:0] FULL_THR = (ADDR_W+1)'(DEPTH - WU);

  logic [ADDR_W-1:0] wptr_d, wptr_q;
  logic [ADDR_W-1:0] rptr_d, rptr_q;
  logic [ADDR_W:0]   level_d, level_q;
  logic              w_full_d, w_full_q;
  logic              r_empty_d, r_empty_q;
  logic              w_acc, r_acc;

  // Both requests judged against pre-edge flags; flags then decoded from the new level
  always_comb begin
    w_acc   = w_en & ~w_full_q & ~rst;
    r_acc   = r_en & ~r_empty_q & ~rst;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (rst) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (w_acc) wptr_d = wptr_q + ADDR_W'(WU);
      if (r_acc) rptr_d = rptr_q + ADDR_W'(RU);
      level_d = level_q + (w_acc ? WU_L : '0) - (r_acc ? RU_L : '0);
    end
    w_full_d  = (level_d > FULL_THR);
    r_empty_d = (level_d < RU_L);
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      w_full_q  <= 1'b0;
      r_empty_q <= 1'b1;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      w_full_q  <= w_full_d;
      r_empty_q <= r_empty_d;
    end
  end

  iob_t2p_asym_ram #(
    .W_DATA_W(W_DATA_W),
    .R_DATA_W(R_DATA_W),
    .ADDR_W  (ADDR_W)
  ) u_ram (
    .wclk  (clk),
    .w_en  (w_acc),
    .w_addr(wptr_q),
    .w_data(w_data),
    .rclk  (clk),
    .arst_n(arst_n),
    .rst   (rst),
    .r_en  (r_acc),
    .r_addr(rptr_q),
    .r_data(r_data)
  );

  assign w_full  = w_full_q;
  assign r_empty = r_empty_q;
  assign level   = level_q;

endmodule

// File: tb/tb_iob_sync_asym_fifo.sv
// tb/tb_iob_sync_asym_fifo.sv - scoreboard bench for wide-to-narrow and narrow-to-wide FIFO instances
module tb_iob_sync_asym_fifo;

  logic        clk;
  logic        arst_n;
  logic        rst_s    [2];
  logic        w_en_s   [2];
  logic [31:0] w_data_s [2];
  logic        r_en_s   [2];

  int n_checks = 0;
  int n_err    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int g, input logic [31:0] act,
                              input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] at %0t: got %h expected %h", nm, g, $time, act, exp);
    end
  endfunction

  // Instance 0: 32-bit writes, 8-bit reads. Instance 1: 8-bit writes, 32-bit reads.
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int WW = (g == 0) ? 32 : 8;
    localparam int RW = (g == 0) ? 8 : 32;
    localparam int WU = WW / 8;
    localparam int RU = RW / 8;

    logic          w_full, r_empty;
    logic [RW-1:0] r_data;
    logic [4:0]    level;

    iob_sync_asym_fifo #(.W_DATA_W(WW), .R_DATA_W(RW), .ADDR_W(4)) u_dut (
      .clk    (clk),
      .arst_n (arst_n),
      .rst    (rst_s[g]),
      .w_en   (w_en_s[g]),
      .w_data (w_data_s[g][WW-1:0]),
      .w_full (w_full),
      .r_en   (r_en_s[g]),
      .r_data (r_data),
      .r_empty(r_empty),
      .level  (level)
    );

    // Reference: a plain byte queue; full/empty derive from its size
    logic [7:0]  mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] last_q;
    logic [31:0] wv;
    int          sz;
    bit          rd_pend;

    always @(posedge clk or negedge arst_n) begin
      if (!arst_n || rst_s[g]) begin
        mq.delete();
        exp_q.delete();
        last_q  = 0;
        rd_pend = 0;
      end else begin
        sz = mq.size();
        rd_pend = 0;
        if (r_en_s[g] && sz >= RU) begin
          wv = 0;
          for (int k = 0; k < RU; k++) wv[k*8 +: 8] = mq.pop_front();
          exp_q.push_back(wv);
          rd_pend = 1;
        end
        if (w_en_s[g] && sz <= 16 - WU) begin
          for (int k = 0; k < WU; k++) mq.push_back(w_data_s[g][k*8 +: 8]);
        end
      end
    end

    always @(negedge clk) begin
      if (arst_n) begin
        chk("level", g, 32'(level), mq.size());
        chk("w_full", g, 32'(w_full), 32'(mq.size() > 16 - WU));
        chk("r_empty", g, 32'(r_empty), 32'(mq.size() < RU));
        if (rd_pend) begin
          rd_pend = 0;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL sb_underrun[%0d]: got no expected word, required one", g);
          end else begin
            last_q = exp_q.pop_front();
          end
        end
        chk("r_data", g, 32'(r_data), last_q & ((RW == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF));
      end
    end
  end

  task automatic op(input int g, input bit we, input logic [31:0] wd, input bit re);
    @(posedge clk);
    #1;
    w_en_s[g]   = we;
    w_data_s[g] = wd;
    r_en_s[g]   = re;
  endtask

  task automatic idle(input int g);
    op(g, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic clr(input int g);
    @(posedge clk);
    #1;
    rst_s[g] = 1'b1;
    w_en_s[g] = 1'b0;
    r_en_s[g] = 1'b0;
    @(posedge clk);
    #1;
    rst_s[g] = 1'b0;
  endtask

  initial begin
    arst_n = 1'b0;
    for (int g = 0; g < 2; g++) begin
      rst_s[g] = 1'b0; w_en_s[g] = 1'b0; w_data_s[g] = '0; r_en_s[g] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("rst_level0", 0, 32'(g_dut[0].level), 0);
    chk("rst_empty0", 0, 32'(g_dut[0].r_empty), 1);
    chk("rst_full0", 0, 32'(g_dut[0].w_full), 0);
    chk("rst_rdata0", 0, 32'(g_dut[0].r_data), 0);
    chk("rst_empty1", 1, 32'(g_dut[1].r_empty), 1);
    chk("rst_rdata1", 1, g_dut[1].r_data, 0);
    @(negedge clk);
    arst_n = 1'b1;

    // Wide write, narrow read: fill, overflow, drain, underflow
    op(0, 1, 32'h2322_2120, 0);
    op(0, 1, 32'h2726_2524, 0);
    op(0, 1, 32'h2B2A_2928, 0);
    op(0, 1, 32'h2F2E_2D2C, 0);
    idle(0);
    chk("t1_full", 0, 32'(g_dut[0].w_full), 1);
    chk("t1_level16", 0, 32'(g_dut[0].level), 16);
    op(0, 1, 32'hDEAD_BEEF, 0);
    idle(0);
    chk("ovf_level", 0, 32'(g_dut[0].level), 16);
    for (int i = 0; i < 16; i++) op(0, 0, 32'h0, 1);
    idle(0);
    chk("t1_empty", 0, 32'(g_dut[0].r_empty), 1);
    chk("t1_level0", 0, 32'(g_dut[0].level), 0);
    chk("t1_last", 0, 32'(g_dut[0].r_data), 32'h2F);
    op(0, 0, 32'h0, 1);
    idle(0);
    chk("udf_hold", 0, 32'(g_dut[0].r_data), 32'h2F);

    // Narrow write, wide read
    for (int i = 0; i < 3; i++) op(1, 1, 32'h20 + i, 0);
    idle(1);
    chk("t2_empty3", 1, 32'(g_dut[1].r_empty), 1);
    op(1, 1, 32'h23, 0);
    idle(1);
    chk("t2_empty4", 1, 32'(g_dut[1].r_empty), 0);
    for (int i = 4; i < 16; i++) op(1, 1, 32'h20 + i, 0);
    for (int i = 0; i < 4; i++) op(1, 0, 32'h0, 1);
    idle(1);
    chk("t2_last", 1, g_dut[1].r_data, 32'h2F2E_2D2C);

    // Three full passes around the pointer space
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) op(0, 1, 32'h0101_0101 * (16*p + 4*i) + 32'h0302_0100, 0);
      for (int i = 0; i < 16; i++) op(0, 0, 32'h0, 1);
      idle(0);
      chk("wrap_level", 0, 32'(g_dut[0].level), 0);
      chk("wrap_last", 0, 32'(g_dut[0].r_data), 32'(16*p + 15));
    end

    // Random traffic on both instances, with occasional synchronous clears
    for (int i = 0; i < 600; i++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
        w_en_s[g]   = 1'($urandom_range(0, 1));
        r_en_s[g]   = 1'($urandom_range(0, 1));
        w_data_s[g] = $urandom;
        rst_s[g]    = ($urandom_range(0, 49) == 0);
      end
    end
    for (int g = 0; g < 2; g++) begin
      w_en_s[g] = 1'b0; r_en_s[g] = 1'b0; rst_s[g] = 1'b0;
    end

    // Simultaneous read and write from level 8
    clr(0);
    chk("clr_level", 0, 32'(g_dut[0].level), 0);
    op(0, 1, 32'h4342_4140, 0);
    op(0, 1, 32'h4746_4544, 0);
    idle(0);
    chk("sim_level8", 0, 32'(g_dut[0].level), 8);
    op(0, 1, 32'h4B4A_4948, 1);
    idle(0);
    chk("sim_level11", 0, 32'(g_dut[0].level), 11);
    chk("sim_rdata", 0, 32'(g_dut[0].r_data), 32'h40);

    // Asynchronous reset mid-cycle
    #3;
    arst_n = 1'b0;
    #1;
    chk("arst_level", 0, 32'(g_dut[0].level), 0);
    chk("arst_empty", 0, 32'(g_dut[0].r_empty), 1);
    chk("arst_full", 0, 32'(g_dut[0].w_full), 0);
    chk("arst_rdata", 0, 32'(g_dut[0].r_data), 0);
    @(posedge clk);
    #3;
    arst_n = 1'b1;
    op(0, 1, 32'hA3A2_A1A0, 0);
    for (int i = 0; i < 4; i++) op(0, 0, 32'h0, 1);
    idle(0);
    chk("post_rdata", 0, 32'(g_dut[0].r_data), 32'hA3);
    chk("post_level", 0, 32'(g_dut[0].level), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/iob_sync_asym_fifo.md
Name: iob_sync_asym_fifo

Overview:
- Single-clock FIFO whose write port and read port have different data widths.
- Ratio between the widths is a power of two.
- Sits between a producer and a consumer of different widths, e.g. a 32-bit bus writer feeding an 8-bit serializer, or the reverse.
- Storage is a two-port asymmetric RAM. The block adds pointers, level counting, full/empty flags and accept/ignore handshakes on top of it.

Parameters:
- W_DATA_W, 32: write data width. Must be a power-of-two multiple or fraction of R_DATA_W.
- R_DATA_W, 8: read data width.
- ADDR_W, 4: log2 of FIFO depth, counted in MIN_W-bit units. MIN_W = min(W_DATA_W, R_DATA_W). Depth = 2^ADDR_W units.

Ports:
- clk  in  1  system clock, rising edge.
- arst_n  in  1  asynchronous active-low reset.
- rst  in  1  synchronous clear of pointers and level; data contents undefined afterwards.
- w_en  in  1  write request.
- w_data  in  W_DATA_W  write word.
- w_full  out  1  a W_DATA_W word cannot be accepted.
- r_en  in  1  read request.
- r_data  out  R_DATA_W  read word.
- r_empty  out  1  a full R_DATA_W word is not available.
- level  out  ADDR_W+1  occupancy in MIN_W units.

Behaviour:
- Derived constants:
  - WU = W_DATA_W/MIN_W units per write.
  - RU = R_DATA_W/MIN_W units per read.
  - Exactly one of WU, RU is greater than 1, or both are 1.
- Reset (arst_n low, or rst high at a clock edge):
  - write and read pointers = 0, level = 0;
  - r_empty = 1, w_full = 0, r_data = 0.
- Flags are registered and decoded from the current level:
  - w_full = (level > 2^ADDR_W - WU);
  - r_empty = (level < RU).
- Write acceptance:
  - Accepted when w_en & ~w_full.
  - Writes WU units at the write pointer. Unit k of w_data (bits [k*MIN_W +: MIN_W]) goes to address wptr+k, little-endian.
  - wptr advances by WU modulo 2^ADDR_W.
- Write ignored when full: w_en with w_full = 1 is dropped. No state change, no error flag.
- Read acceptance:
  - Accepted when r_en & ~r_empty.
  - rptr advances by RU modulo 2^ADDR_W.
  - r_data is updated on the clock edge after acceptance (1-cycle latency). Unit k of r_data comes from address rptr+k.
  - r_data holds its value until the next accepted read.
- Read ignored when empty: r_en with r_empty = 1 is dropped; r_data holds.
- Simultaneous accepted read and write:
  - Both are evaluated against the pre-edge level.
  - level_next = level + WU - RU.
  - No read-during-write bypass. A read while empty is never accepted, so first-word fall-through does not exist.
- Pointer and level rules:
  - Pointers are ADDR_W bits and wrap naturally.
  - level is ADDR_W+1 bits and saturates by construction at 2^ADDR_W; it can never exceed the depth.
  - Because WU and RU divide the depth, accesses never straddle the wrap boundary in a misaligned way.
- Reset mid-operation: an asynchronous assert clears everything within the same cycle. Requests present during reset are dropped.
- Flag timing: w_full and r_empty reflect level after each edge, so there is no combinational path from w_en or r_en to the flags.

Decomposition:
- Shared package: MIN_W, WU, RU derivation functions, and a clog2 helper.
- Sub-module: iob_t2p_asym_ram, the team's asymmetric two-port RAM, used as storage with wclk = rclk = clk. Interface:
  - write side: w_en, w_addr, w_data;
  - read side: r_en, r_addr, r_data, registered read.
- The FIFO top holds the pointer, level and flag logic and the read-enable gating.

Test Plan:
- W=32, R=8, ADDR_W=4:
  - stimulus: write 0x23222120, 0x27262524, 0x2B2A2928, 0x2F2E2D2C;
  - expect: w_full = 1 after the 4th write, level = 16;
  - then read 16 times; expect r_data = 0x20..0x2F in order, r_empty = 1 after the last read, level = 0.
- W=8, R=32:
  - stimulus: write bytes 0x20..0x2F;
  - expect: r_empty falls after the 4th byte;
  - then 4 reads; expect r_data = 0x23222120, 0x27262524, 0x2B2A2928, 0x2F2E2D2C.
- Overflow and underflow (W=32, R=8):
  - 5th write while full with 0xDEADBEEF → ignored, level stays 16;
  - read when empty → ignored, r_data holds the previous byte.
- Wrap-around: write 4, read 16, repeated 3 times with incrementing data → data order preserved across pointer wrap, level returns to 0 each pass.
- Simultaneous access: level = 8, assert w_en and r_en in the same cycle → level = 8 + 4 - 1 = 11, both accepted.
- Reset mid-stream: arst_n low while level = 11 → level = 0, r_empty = 1, w_full = 0, r_data = 0 immediately. After release, the next write/read round trip returns fresh data.
